// File: rtl/sprite_rom_arbiter_if.sv
// Request/ROM/return bundle shared by the sprite ROM arbiter and its environment.
// The slave side is the arbiter; the master side drives requests, ROM data and frame ticks.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 12
);
    logic                     frame_tick;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*ADDR_W-1:0]  addr;
    logic [N_REQ-1:0]         gnt;
    logic                     rom_en;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic [N_REQ-1:0]         rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic [N_REQ-1:0]         starve;

    modport master (
        output frame_tick, req, addr, rom_data,
        input  gnt, rom_en, rom_addr, rd_valid, rd_data, starve
    );

    modport slave (
        input  frame_tick, req, addr, rom_data,
        output gnt, rom_en, rom_addr, rd_valid, rd_data, starve
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Single-port sprite ROM arbiter: requester 0 strict priority, others round-robin, tagged returns.
// Latency: accept -> rd_valid in ROM_LAT+2 cycles; one access per cycle; requesters hold req until gnt.
module sprite_rom_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 12,
    parameter int ROM_LAT  = 2,
    parameter int MAX_WAIT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sprite_rom_arbiter_if.slave   bus
);
    localparam int PTR_W  = $clog2(N_REQ);
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    logic [PTR_W-1:0]   rr_ptr_q;
    logic               rom_en_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [N_REQ-1:0]   tag_q [ROM_LAT+1];
    logic [N_REQ-1:0]   rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic [N_REQ-1:0]   starve_q, starve_d;
    logic [WAIT_W-1:0]  wait_q [N_REQ];
    logic [WAIT_W-1:0]  wait_d [N_REQ];

    logic [N_REQ-1:0]   gnt_c;
    logic [PTR_W-1:0]   gnt_idx;
    logic               found;
    logic [ADDR_W-1:0]  acc_addr;

    // Low-priority search starts just after the last low-priority winner, skipping index 0.
    always_comb begin
        int               j;
        logic [PTR_W-1:0] jj;
        gnt_c   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        if (rst_n) begin
            if (bus.req[0]) begin
                gnt_c[0] = 1'b1;
                found    = 1'b1;
            end else begin
                for (int k = 1; k < N_REQ; k++) begin
                    j = int'(rr_ptr_q) + k;
                    if (j > N_REQ - 1) j = j - (N_REQ - 1);
                    jj = PTR_W'(j);
                    if (!found && bus.req[jj]) begin
                        found     = 1'b1;
                        gnt_c[jj] = 1'b1;
                        gnt_idx   = jj;
                    end
                end
            end
        end
    end

    assign acc_addr = bus.addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

    always_comb begin
        starve_d = starve_q;
        for (int i = 0; i < N_REQ; i++) wait_d[i] = wait_q[i];
        if (bus.frame_tick) begin
            starve_d = '0;
            for (int i = 0; i < N_REQ; i++) wait_d[i] = '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req[i] && !gnt_c[i]) begin
                    if (wait_q[i] != '1) wait_d[i] = wait_q[i] + 1'b1;
                end else begin
                    wait_d[i] = '0;
                end
                if (wait_d[i] > WAIT_LIM) starve_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= PTR_W'(N_REQ - 1);
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            starve_q   <= '0;
            for (int s = 0; s <= ROM_LAT; s++) tag_q[s] <= '0;
            for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
        end else begin
            rom_en_q <= found;
            if (found) rom_addr_q <= acc_addr;
            if (found && !gnt_c[0]) rr_ptr_q <= gnt_idx;
            // Tag rides alongside the ROM access so the return is steered to its requester.
            tag_q[0] <= gnt_c;
            for (int s = 1; s <= ROM_LAT; s++) tag_q[s] <= tag_q[s-1];
            rd_valid_q <= tag_q[ROM_LAT];
            if (|tag_q[ROM_LAT]) rd_data_q <= bus.rom_data;
            starve_q <= starve_d;
            for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.starve   = starve_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed stimulus, a cycle-indexed behavioural model and literal pins.
module tb_sprite_rom_arbiter;
    localparam int N   = 4;
    localparam int AW  = 14;
    localparam int DW  = 12;
    localparam int LAT = 2;
    localparam int MW  = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    sprite_rom_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .MAX_WAIT(MW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        int v;
        v = int'(a) * 7 + 3;
        return v[DW-1:0];
    endfunction

    // ROM with LAT cycles from the rom_en cycle to valid data.
    logic [AW-1:0] rp [LAT] = '{default: '0};
    always @(posedge clk) begin
        rp[0] <= bus.rom_addr;
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign bus.rom_data = rom_f(rp[LAT-1]);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              cyc = 0;
    int              m_ptr = N - 1;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_rd = '0;
    logic [N-1:0]    m_starve = '0;
    int              wc [N] = '{default: 0};
    bit              en_at [int];
    logic [N-1:0]    rv_at [int];
    logic [DW-1:0]   rd_at [int];

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        int j;
        g = '0;
        if (rst_n !== 1'b1) return g;
        if (bus.req[0]) begin
            g[0] = 1'b1;
            return g;
        end
        for (int k = 1; k < N; k++) begin
            j = m_ptr + k;
            if (j > N - 1) j = j - (N - 1);
            if (bus.req[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    always @(posedge clk) begin : model
        logic [N-1:0] g;
        int idx;
        g = m_gnt();
        if (rst_n !== 1'b1) begin
            en_at.delete(); rv_at.delete(); rd_at.delete();
            m_addr = '0; m_rd = '0; m_starve = '0; m_ptr = N - 1;
            for (int i = 0; i < N; i++) wc[i] = 0;
        end else begin
            if (g != '0) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (g[i]) idx = i;
                m_addr = bus.addr[idx*AW +: AW];
                en_at[cyc+1] = 1'b1;
                rv_at[cyc+2+LAT] = g;
                rd_at[cyc+2+LAT] = rom_f(m_addr);
                if (idx != 0) m_ptr = idx;
            end
            if (bus.frame_tick) begin
                m_starve = '0;
                for (int i = 0; i < N; i++) wc[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (bus.req[i] && !g[i]) wc[i]++;
                    else wc[i] = 0;
                    if (wc[i] > MW) m_starve[i] = 1'b1;
                end
            end
        end
        cyc++;
        if (rv_at.exists(cyc)) m_rd = rd_at[cyc];
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("gnt",      32'(bus.gnt),      32'(m_gnt()));
            check("rom_en",   32'(bus.rom_en),   32'(en_at.exists(cyc)));
            check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
            check("rd_valid", 32'(bus.rd_valid), 32'(rv_at.exists(cyc) ? rv_at[cyc] : '0));
            check("rd_data",  32'(bus.rd_data),  32'(m_rd));
            check("starve",   32'(bus.starve),   32'(m_starve));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                        input logic ft, input logic rn);
        @(posedge clk);
        #1;
        bus.req = r;
        bus.addr = a;
        bus.frame_tick = ft;
        rst_n = rn;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N-1:0] seq [6];
        logic [N*AW-1:0] rr_a;
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        rr_a = {14'h303, 14'h202, 14'h101, 14'h000};

        rst_n = 1'b0; bus.req = '0; bus.addr = '0; bus.frame_tick = 1'b0;
        step('0, '0, 1'b0, 1'b1);
        check("rst_rom_en",   32'(bus.rom_en),   32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_starve",   32'(bus.starve),   32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);

        // single request from requester 1
        step(4'b0010, {14'h0, 14'h0, 14'h123, 14'h0}, 1'b0, 1'b1);
        check("single_gnt", 32'(bus.gnt), 32'h2);
        step('0, '0, 1'b0, 1'b1);
        check("single_rom_en",   32'(bus.rom_en),   32'd1);
        check("single_rom_addr", 32'(bus.rom_addr), 32'h123);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        check("single_rd_valid", 32'(bus.rd_valid), 32'h2);
        check("single_rd_data",  32'(bus.rd_data),  32'h7F8);

        // requester 0 beats requester 1
        step(4'b0011, {14'h0, 14'h0, 14'h055, 14'h044}, 1'b0, 1'b1);
        check("prio_gnt0", 32'(bus.gnt), 32'h1);
        step(4'b0010, {14'h0, 14'h0, 14'h055, 14'h044}, 1'b0, 1'b1);
        check("prio_gnt1", 32'(bus.gnt), 32'h2);
        for (int i = 0; i < 5; i++) step('0, '0, 1'b0, 1'b1);

        // back-to-back accesses from requester 0
        step(4'b0001, {42'h0, 14'h010}, 1'b0, 1'b1);
        step(4'b0001, {42'h0, 14'h011}, 1'b0, 1'b1);
        step(4'b0001, {42'h0, 14'h012}, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        check("pipe_v0", 32'(bus.rd_valid), 32'h1);
        check("pipe_d0", 32'(bus.rd_data),  32'h073);
        step('0, '0, 1'b0, 1'b1);
        check("pipe_v1", 32'(bus.rd_valid), 32'h1);
        check("pipe_d1", 32'(bus.rd_data),  32'h07A);
        step('0, '0, 1'b0, 1'b1);
        check("pipe_v2", 32'(bus.rd_valid), 32'h1);
        check("pipe_d2", 32'(bus.rd_data),  32'h081);
        step('0, '0, 1'b0, 1'b1);
        check("pipe_end", 32'(bus.rd_valid), 32'h0);

        // requester-0 grants must not have moved the pointer off requester 1
        step(4'b1110, rr_a, 1'b0, 1'b1);
        check("ptr_kept_gnt", 32'(bus.gnt), 32'h4);
        for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b1);

        // starvation of requester 2 behind requester 0
        for (int i = 0; i < 40; i++) begin
            step(4'b0101, rr_a, 1'b0, 1'b1);
            if (i == 32) check("starve_pre",  32'(bus.starve), 32'h0);
            if (i == 33) check("starve_set",  32'(bus.starve), 32'h4);
            if (i == 39) check("starve_held", 32'(bus.starve), 32'h4);
        end
        step('0, '0, 1'b0, 1'b1);
        check("starve_sticky", 32'(bus.starve), 32'h4);
        step('0, '0, 1'b1, 1'b1);
        check("starve_tick_cycle", 32'(bus.starve), 32'h4);
        step('0, '0, 1'b0, 1'b1);
        check("starve_cleared", 32'(bus.starve), 32'h0);
        for (int i = 0; i < 5; i++) step('0, '0, 1'b0, 1'b1);

        // reset with a read in flight, then round-robin from reset state
        step(4'b1000, {14'h200, 42'h0}, 1'b0, 1'b1);
        check("mid_gnt", 32'(bus.gnt), 32'h8);
        step(4'b1110, rr_a, 1'b0, 1'b0);
        check("mid_gnt_in_rst", 32'(bus.gnt),    32'h0);
        check("mid_rom_en",     32'(bus.rom_en), 32'd1);
        for (int k = 0; k < 6; k++) begin
            step(4'b1110, rr_a, 1'b0, 1'b1);
            check("rr_gnt", 32'(bus.gnt), 32'(seq[k]));
            if (k == 0) begin
                check("post_rst_rom_en",  32'(bus.rom_en),  32'd0);
                check("post_rst_rd_data", 32'(bus.rd_data), 32'd0);
            end
            if (k == 2) check("discarded_rd_valid", 32'(bus.rd_valid), 32'h0);
            if (k >= 4) check("rr_rd_valid", 32'(bus.rd_valid), 32'(seq[k-4]));
        end
        for (int j = 0; j < 6; j++) begin
            step('0, '0, 1'b0, 1'b1);
            if (j < 4) check("rr_rd_valid_tail", 32'(bus.rd_valid), 32'(seq[j+2]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
